// File: rtl/plot_buffer.sv
// Pixel plot buffer: FIFO between draw sequencers and the VGA adapter.
// Also performs full-screen clear sweeps after reset and on request.
module plot_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int X_MAX  = 159,
    parameter int Y_MAX  = 119
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_x,
    input  logic [6:0]        in_y,
    input  logic [2:0]        in_colour,
    input  logic              clear_req,
    input  logic [2:0]        clear_colour,
    output logic [7:0]        out_x,
    output logic [6:0]        out_y,
    output logic [2:0]        out_colour,
    output logic              out_plot,
    output logic              busy,
    output logic [ADDR_W:0]   count
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam logic [7:0]      XM       = X_MAX[7:0];
    localparam logic [6:0]      YM       = Y_MAX[6:0];
    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

    state_t              state;
    state_t              state_next;
    logic [17:0]         mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [7:0]          sx;
    logic [6:0]          sy;
    logic [2:0]          fill;
    logic                push;
    logic                wr_en;
    logic                pop;
    logic                sweep_last;

    assign in_ready   = resetn && (count != FULL_CNT);
    assign push       = in_valid && in_ready;
    // Off-screen requests are consumed but never stored
    assign wr_en      = push && (in_x <= XM) && (in_y <= YM);
    assign pop        = (state == RUN) && (count != '0) && !clear_req;
    assign sweep_last = (sx == XM) && (sy == YM);
    assign busy       = (state == CLEAR) || (count != '0);

    always_comb begin
        state_next = state;
        unique case (state)
            CLEAR:   if (sweep_last) state_next = RUN;
            RUN:     if (clear_req) state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= {in_x, in_y, in_colour};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= CLEAR;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            sx         <= '0;
            sy         <= '0;
            fill       <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_colour <= '0;
            out_plot   <= 1'b0;
        end else begin
            state <= state_next;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop);

            if (state == CLEAR) begin
                out_x      <= sx;
                out_y      <= sy;
                out_colour <= fill;
                out_plot   <= 1'b1;
                if (sx == XM) begin
                    sx <= '0;
                    sy <= sy + 1'b1;
                end else begin
                    sx <= sx + 1'b1;
                end
            end else if (clear_req) begin
                // Arm a new sweep; this edge emits nothing
                fill     <= clear_colour;
                sx       <= '0;
                sy       <= '0;
                out_plot <= 1'b0;
            end else if (pop) begin
                {out_x, out_y, out_colour} <= mem[rd_ptr];
                out_plot <= 1'b1;
            end else begin
                out_plot <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_plot_buffer.sv
// Self-checking bench for plot_buffer: scoreboard of expected plotted
// pixels plus a vector table for latency and clipping behaviour.
module tb_plot_buffer;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        bit         wr;
    } vec_t;

    logic       clock;
    logic       resetn;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [6:0] in_y;
    logic [2:0] in_colour;
    logic       clear_req;
    logic [2:0] clear_colour;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       out_plot;
    logic       busy;
    logic [4:0] count;

    int   checks   = 0;
    int   failures = 0;
    int   mon_err  = 0;
    int   mon_cnt  = 0;
    int   mon_base = 0;
    bit   mon_en   = 0;
    pix_t exp_q[$];

    plot_buffer dut (
        .clock        (clock),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_colour    (in_colour),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_colour   (out_colour),
        .out_plot     (out_plot),
        .busy         (busy),
        .count        (count)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // Scoreboard: every plotted pixel must match the queue head
    always @(negedge clock) begin
        if (mon_en && resetn && out_plot) begin
            mon_cnt++;
            if (exp_q.size() == 0) begin
                mon_err++;
                if (mon_err <= 5)
                    $display("mon: unexpected plot (%0d,%0d,%0d)",
                             out_x, out_y, out_colour);
            end else begin
                pix_t e;
                e = exp_q.pop_front();
                if (e.x != out_x || e.y != out_y || e.c != out_colour) begin
                    mon_err++;
                    if (mon_err <= 5)
                        $display("mon: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                                 out_x, out_y, out_colour, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic check(input string name, input longint act,
                         input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic push_sweep(input logic [2:0] col);
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++) begin
                pix_t p;
                p.x = 8'(x);
                p.y = 7'(y);
                p.c = col;
                exp_q.push_back(p);
            end
    endtask

    task automatic exp_push(input logic [7:0] x, input logic [6:0] y,
                            input logic [2:0] c);
        pix_t p;
        p.x = x;
        p.y = y;
        p.c = c;
        exp_q.push_back(p);
    endtask

    task automatic drive(input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c);
        in_valid  = 1;
        in_x      = x;
        in_y      = y;
        in_colour = c;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic wait_count(input string name, input int want,
                              input int budget);
        int n = 0;
        while (count != want && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, count, want);
    endtask

    task automatic sb_done(input string name, input int plots);
        check({name, "_mon_err"}, mon_err, 0);
        check({name, "_q_left"}, exp_q.size(), 0);
        check({name, "_plots"}, mon_cnt - mon_base, plots);
        mon_err  = 0;
        mon_base = mon_cnt;
    endtask

    vec_t vt[7];

    initial begin
        int bad;
        vt[0] = '{8'd10,  7'd20,  3'b111, 1'b1};
        vt[1] = '{8'd255, 7'd127, 3'b111, 1'b0};
        vt[2] = '{8'd160, 7'd5,   3'b111, 1'b0};
        vt[3] = '{8'd159, 7'd119, 3'b010, 1'b1};
        vt[4] = '{8'd0,   7'd0,   3'b101, 1'b1};
        vt[5] = '{8'd5,   7'd120, 3'b001, 1'b0};
        vt[6] = '{8'd159, 7'd0,   3'b100, 1'b1};

        in_valid     = 0;
        in_x         = 0;
        in_y         = 0;
        in_colour    = 0;
        clear_req    = 0;
        clear_colour = 0;
        resetn       = 1;
        #2 resetn = 0;
        repeat (3) @(negedge clock);

        check("rst_out_x", out_x, 0);
        check("rst_out_y", out_y, 0);
        check("rst_out_colour", out_colour, 0);
        check("rst_out_plot", out_plot, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_count", count, 0);

        // Initial black sweep
        push_sweep(3'b000);
        mon_en = 1;
        resetn = 1;
        wait_idle("init_sweep_timeout", 19400);
        @(negedge clock);
        check("init_plot_after", out_plot, 0);
        check("init_busy_after", busy, 0);
        sb_done("init_sweep", 19200);

        // Vector table: latency and clipping
        foreach (vt[i]) begin
            drive(vt[i].x, vt[i].y, vt[i].c);
            if (vt[i].wr) exp_push(vt[i].x, vt[i].y, vt[i].c);
            check($sformatf("vec%0d_ready", i), in_ready, 1);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_count_n", i), count, vt[i].wr);
            check($sformatf("vec%0d_plot_n", i), out_plot, 0);
            @(negedge clock);
            in_valid = 0;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_plot_n1", i), out_plot, vt[i].wr);
            check($sformatf("vec%0d_count_n1", i), count, 0);
            @(negedge clock);
        end
        @(negedge clock);
        sb_done("vec", 4);

        // Blue clear while filling the FIFO
        push_sweep(3'b001);
        clear_req    = 1;
        clear_colour = 3'b001;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] x;
            logic [6:0] y;
            logic [2:0] c;
            x = 8'(i * 9);
            y = 7'(i + 3);
            c = 3'(i);
            drive(x, y, c);
            exp_push(x, y, c);
            @(negedge clock);
            clear_req = 0;
        end
        drive(8'd1, 8'd1, 3'd1);
        check("full_ready", in_ready, 0);
        check("full_count", count, 16);
        repeat (3) @(negedge clock);
        check("full_no_overflow", count, 16);
        in_valid = 0;
        repeat (100) @(negedge clock);
        clear_req    = 1;
        clear_colour = 3'b100;
        @(negedge clock);
        clear_req = 0;
        check("clear_busy", busy, 1);
        check("clear_hold_count", count, 16);
        wait_count("first_pop", 15, 19400);
        check("ready_after_pop", in_ready, 1);
        wait_count("drain_to_8", 8, 20);

        // Steady push+pop at occupancy 8
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            logic [7:0] x;
            logic [6:0] y;
            logic [2:0] c;
            x = 8'($urandom_range(159));
            y = 7'($urandom_range(119));
            c = 3'($urandom_range(7));
            drive(x, y, c);
            exp_push(x, y, c);
            @(posedge clock);
            #1;
            if (count != 8) bad++;
            @(negedge clock);
        end
        in_valid = 0;
        check("steady_count_bad_cycles", bad, 0);
        wait_idle("blue_drain_timeout", 100);
        repeat (3) @(negedge clock);
        sb_done("blue", 19200 + 16 + 100);

        // Reset in the middle of a clear with entries queued
        mon_en       = 0;
        clear_req    = 1;
        clear_colour = 3'b011;
        @(negedge clock);
        clear_req = 0;
        for (int i = 0; i < 5; i++) begin
            drive(8'(20 + i), 7'(30 + i), 3'b110);
            @(negedge clock);
        end
        in_valid = 0;
        repeat (300) @(negedge clock);
        check("mid_count", count, 5);
        resetn = 0;
        #1;
        check("mid_rst_out_x", out_x, 0);
        check("mid_rst_out_y", out_y, 0);
        check("mid_rst_out_colour", out_colour, 0);
        check("mid_rst_out_plot", out_plot, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_busy", busy, 1);
        @(negedge clock);
        exp_q.delete();
        push_sweep(3'b000);
        mon_err  = 0;
        mon_base = mon_cnt;
        mon_en   = 1;
        resetn   = 1;
        wait_idle("rst_sweep_timeout", 19400);
        repeat (10) @(negedge clock);
        check("rst_sweep_plot_after", out_plot, 0);
        sb_done("rst_sweep", 19200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/plot_buffer.md
Name: plot_buffer

Overview:
- Sits between the bird/hunter draw sequencer and the VGA adapter.
- Accepts pixel write requests (x, y, colour) through a valid/ready handshake and buffers them in a FIFO.
- Drains one pixel per cycle onto a registered plot interface (out_x, out_y, out_colour, out_plot) that drives the adapter's x/y/colour/plot inputs.
- Owns full-screen clear: sweeps all 160x120 pixels after reset and on request, so draw FSMs never issue background fills.

Parameters:
DEPTH, 16, FIFO entries (power of two)
ADDR_W, 4, log2(DEPTH)
X_MAX, 159, last valid column
Y_MAX, 119, last valid row

Ports:
clock  in  1  system clock (CLOCK_50 at top level)
resetn  in  1  asynchronous active-low reset
in_valid  in  1  pixel request present
in_ready  out  1  buffer can accept (= FIFO not full)
in_x  in  8  request column
in_y  in  7  request row
in_colour  in  3  request colour {R,G,B}
clear_req  in  1  single-cycle pulse: start screen clear
clear_colour  in  3  fill colour, sampled with clear_req
out_x  out  8  registered plot column
out_y  out  7  registered plot row
out_colour  out  3  registered plot colour
out_plot  out  1  registered write strobe, one pixel per high cycle
busy  out  1  high in CLEAR state or FIFO non-empty
count  out  ADDR_W+1  current FIFO occupancy

Behaviour:
- Reset (async, resetn=0): FIFO empty, count=0, state=CLEAR, sweep x=0 and y=0, fill colour=3'b000. Outputs out_x=0, out_y=0, out_colour=0, out_plot=0, in_ready=0 while resetn=0, busy=1.
- States:
  - CLEAR: sweep emits pixels.
  - RUN: FIFO drains.
- CLEAR:
  - Each edge registers out_x=sx, out_y=sy, out_colour=fill colour, out_plot=1.
  - sx increments 0..X_MAX. At X_MAX it wraps to 0 and sy increments.
  - After emitting (X_MAX,Y_MAX), the next state is RUN.
  - Exactly (X_MAX+1)*(Y_MAX+1)=19200 plot cycles per clear. The first is (0,0) on the first edge after reset release.
  - FIFO does not pop during CLEAR. It still accepts pushes while not full.
  - clear_req during CLEAR is ignored; the sweep does not restart.
- RUN:
  - FIFO non-empty: each edge pops the head into out_x/out_y/out_colour and sets out_plot=1.
  - FIFO empty: out_plot=0; out_x/out_y/out_colour hold their last values.
- clear_req in RUN:
  - Latch clear_colour, reset sx and sy to 0, and enter CLEAR on the same edge.
  - The first sweep pixel appears on the following edge.
  - That edge performs no pop; the FIFO contents are preserved and drain after the sweep.
- Latency: a request accepted at edge N into an empty FIFO in RUN appears with out_plot=1 after edge N+1.
- Handshake:
  - Push occurs when in_valid && in_ready at a rising edge.
  - in_ready = ~full and is combinational from count. It does not account for a same-cycle pop.
  - in_x/in_y/in_colour need only be stable while in_valid is high.
- Clipping:
  - A request with in_x>X_MAX or in_y>Y_MAX is handshaken (consumed, in_ready unaffected) but not written. count is unchanged.
  - This covers the 8'hFF / 7'h7F idle coordinates produced by draw sequencers.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- Full: in_ready=0, no write, no overflow.
- Empty pop: never occurs.
- Pointers are ADDR_W bits and wrap modulo DEPTH. count ranges 0..DEPTH.
- busy = (state==CLEAR) || (count!=0).
- Async reset mid-operation: immediate return to reset values and a fresh black sweep; buffered pixels are discarded.

Test Plan:
- Release reset, hold in_valid=0 -> exactly 19200 out_plot cycles with colour 000. First (0,0), row break (159,0) then (0,1), last (159,119). Then out_plot=0, busy=0.
- After the initial sweep, push (10,20,3'b111) at edge N -> out_plot=1 with (10,20,111) after edge N+1 only; count returns to 0.
- Assert clear_req with clear_colour=3'b001 in RUN while pushing 16 pixels -> in_ready drops when count=16. A 19200-pixel blue sweep runs, then the 16 pixels drain in push order; in_ready rises after the first pop.
- Push (255,127,111) and (160,5,111) -> both handshaken, count stays 0, no plot emitted.
- Continuous push/pop with count=8 for 100 cycles -> count stays 8, output sequence equals input sequence.
- Pulse resetn=0 midway through a clear with 5 entries queued -> outputs go to 0 immediately, count=0. A new sweep restarts at (0,0) with colour 000, and the queued entries are never plotted.
